// File: rtl/seq_divider_12.sv
// seq_divider_12 -- iterative restoring divider, one quotient bit per clock.
//
// Computes quotient and remainder of two WIDTH-bit operands using a
// WIDTH+1-bit trial subtractor. It is meant to sit between producers of
// multiplier results and downstream consumers, with a valid/ready handshake
// on each side.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (deasserted synchronously inside)
//   in_valid     operands presented on dividend/divisor
//   in_ready     divider can accept operands (high only in IDLE)
//   dividend     numerator, WIDTH bits
//   divisor      denominator, WIDTH bits
//   out_valid    result held on quotient/remainder/div_by_zero
//   out_ready    consumer accepts the result
//   quotient     dividend / divisor
//   remainder    dividend mod divisor
//   div_by_zero  divisor was zero for this result
//
// Build option:
//   DIV_SIGNED_EN  when defined, operands and results are two's complement.
//                  The quotient truncates toward zero and the remainder takes
//                  the sign of the dividend. When undefined, the divider is
//                  purely unsigned and no sign logic exists.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. On the input side in_ready is a registered
// flag that is high only while idle. On the output side out_valid stays
// high and all result outputs stay bit-stable until out_ready is seen.
// Every output is registered, so no combinational path runs from in_valid or
// out_ready to any output.
//
// Latency: operands accepted on edge N raise out_valid after edge N+WIDTH.
// If out_ready is held high, one result is produced every WIDTH+2 cycles.

module seq_divider_12 #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // FSM encoding. State is kept in a plain internal register named "state"
  // so that checkers can bind to it directly.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  // Reset synchronizer: assertion takes effect at once, and release is aligned
  // to the clock so the FSM never leaves reset on a partial edge.
  logic [1:0] rst_pipe;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];

  // Working registers.
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work_quo;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] work_rem;   // partial remainder
  logic [WIDTH-1:0] work_dvs;   // latched divisor (magnitude in signed builds)
  logic             zero_flag;  // latched divisor == 0

`ifdef DIV_SIGNED_EN
  logic             neg_quo;    // operand signs differ and divisor is non-zero
  logic             neg_rem;    // dividend was negative
`endif

  // Operand conditioning at load time.
  logic [WIDTH-1:0] load_dvd;
  logic [WIDTH-1:0] load_dvs;

  always_comb begin
`ifdef DIV_SIGNED_EN
    // Taking the magnitude of -2^(WIDTH-1) gives 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit value, so the core needs no extra bit.
    load_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    load_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    load_dvd = dividend;
    load_dvs = divisor;
`endif
  end

  // One restoring step. The shifted partial remainder is WIDTH+1 bits wide, so
  // the borrow out of the trial subtraction (trial[WIDTH]) is the sign of the
  // trial. A zero divisor always yields a non-negative trial. That gives an
  // all-ones quotient and leaves the dividend as the remainder, with no
  // special-case logic.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

  always_comb begin
    shifted  = {work_rem, work_quo[WIDTH-1]};
    trial    = shifted - {1'b0, work_dvs};
    q_bit    = ~trial[WIDTH];
    next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    next_quo = {work_quo[WIDTH-2:0], q_bit};
`ifdef DIV_SIGNED_EN
    // Sign correction is applied to the last step's result as it is
    // registered into the outputs, so it adds no cycle.
    fin_quo = neg_quo ? -next_quo : next_quo;
    fin_rem = neg_rem ? -next_rem : next_rem;
`else
    fin_quo = next_quo;
    fin_rem = next_rem;
`endif
  end

  // Main FSM and datapath.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      work_quo    <= '0;
      work_rem    <= '0;
      work_dvs    <= '0;
      zero_flag   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
`endif
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            work_quo  <= load_dvd;
            work_rem  <= '0;
            work_dvs  <= load_dvs;
            zero_flag <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            // Divide by zero keeps the all-ones quotient un-negated. The
            // remainder negation restores the original signed dividend.
            neg_quo   <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && (divisor != '0);
            neg_rem   <= dividend[WIDTH-1];
`endif
            cnt       <= CNT_LAST;
            in_ready  <= 1'b0;
            state     <= ST_CALC;
          end
        end

        ST_CALC: begin
          work_quo <= next_quo;
          work_rem <= next_rem;
          if (cnt == '0) begin
            quotient    <= fin_quo;
            remainder   <= fin_rem;
            div_by_zero <= zero_flag;
            out_valid   <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_DONE: begin
          // The result stays on the outputs until it is consumed. in_ready
          // rises only on the following cycle, so a result is never consumed
          // and new operands accepted on the same edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_12.sv
// tb_seq_divider_12 -- directed self-checking bench for seq_divider_12.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed constants.

module tb_seq_divider_12;

  localparam int W = 12;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total;
  int bad;

  seq_divider_12 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check12(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents the operands for exactly one accept edge, and
  // then counts the cycles until out_valid. It checks the latency and that
  // in_ready stayed low throughout the calculation.
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int lat;
    logic ir_hi;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat   = 0;
    ir_hi = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) ir_hi = 1'b1;
      @(negedge clk);
      lat++;
    end
    check12({tag, "_lat"}, W'(lat), W'(12));
    check1({tag, "_calc_rdy_lo"}, ir_hi, 1'b0);
  endtask

  // Checks the presented result. If out_ready is high, it also checks the
  // handoff back to idle on the next cycle.
  task automatic result(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz);
    check1({tag, "_ov"}, out_valid, 1'b1);
    check12({tag, "_q"}, quotient, eq);
    check12({tag, "_r"}, remainder, er);
    check1({tag, "_dz"}, div_by_zero, edz);
    check1({tag, "_done_rdy"}, in_ready, 1'b0);
    if (out_ready) begin
      @(negedge clk);
      check1({tag, "_ov_drop"}, out_valid, 1'b0);
      check1({tag, "_rdy_back"}, in_ready, 1'b1);
    end
  endtask

  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    issue(tag, a, b);
    result(tag, eq, er, edz);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check12("rst_quotient", quotient, 12'h000);
    check12("rst_remainder", remainder, 12'h000);
    check1("rst_dz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic and boundary operands.
    do_div("100_7", 12'd100, 12'd7, 12'd14, 12'd2, 1'b0);
    do_div("4095_1", 12'hFFF, 12'd1, 12'hFFF, 12'd0, 1'b0);
    do_div("4095_4095", 12'hFFF, 12'hFFF, 12'd1, 12'd0, 1'b0);
`ifdef DIV_SIGNED_EN
    do_div("3_4095", 12'd3, 12'hFFF, 12'hFFD, 12'd0, 1'b0);
`else
    do_div("3_4095", 12'd3, 12'hFFF, 12'd0, 12'd3, 1'b0);
`endif
    do_div("5_0", 12'd5, 12'd0, 12'hFFF, 12'd5, 1'b1);

    // Back-pressure: the result is held while a new in_valid is ignored.
    out_ready = 1'b0;
    issue("bp", 12'd200, 12'd9);
    result("bp", 12'd22, 12'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check1("bp_hold_ov", out_valid, 1'b1);
      check12("bp_hold_q", quotient, 12'd22);
      check12("bp_hold_r", remainder, 12'd2);
      check1("bp_hold_rdy", in_ready, 1'b0);
      in_valid = 1'b1;
      dividend = 12'd77;
      divisor  = 12'd3;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_ov", out_valid, 1'b0);
    check1("bp_release_rdy", in_ready, 1'b1);
    @(negedge clk);
    check1("bp_no_accept", in_ready, 1'b1);

    // Reset during CALC discards the operation immediately.
    in_valid = 1'b1;
    dividend = 12'd1000;
    divisor  = 12'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_ov", out_valid, 1'b0);
    check12("mid_rst_q", quotient, 12'd0);
    check12("mid_rst_r", remainder, 12'd0);
    check1("mid_rst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_div("50_5", 12'd50, 12'd5, 12'd10, 12'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    do_div("m100_7", 12'hF9C, 12'd7, 12'hFF2, 12'hFFE, 1'b0);
    do_div("100_m7", 12'd100, 12'hFF9, 12'hFF2, 12'd2, 1'b0);
    do_div("m2048_m1", 12'h800, 12'hFFF, 12'h800, 12'd0, 1'b0);
    do_div("m5_0", 12'hFFB, 12'd0, 12'hFFF, 12'hFFB, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
